// File: rtl/uart_pkg.sv
// uart_pkg: register map, STATUS/CTRL bit indices and TX/RX state encodings for uart_multi.
package uart_pkg;
  localparam logic [2:0] ADDR_TXDATA = 3'd0;
  localparam logic [2:0] ADDR_RXDATA = 3'd1;
  localparam logic [2:0] ADDR_DIV_LO = 3'd2;
  localparam logic [2:0] ADDR_DIV_HI = 3'd3;
  localparam logic [2:0] ADDR_STATUS = 3'd4;
  localparam logic [2:0] ADDR_CTRL   = 3'd5;
  localparam int ST_TX_EMPTY   = 0;
  localparam int ST_TX_FULL    = 1;
  localparam int ST_RX_EMPTY   = 2;
  localparam int ST_RX_FULL    = 3;
  localparam int ST_OVERRUN    = 4;
  localparam int ST_FRAME_ERR  = 5;
  localparam int ST_PARITY_ERR = 6;
  localparam int CT_PAR_EN   = 0;
  localparam int CT_PAR_ODD  = 1;
  localparam int CT_TWO_STOP = 2;
  localparam int CT_IE_RX    = 3;
  localparam int CT_IE_TX    = 4;
  localparam logic [2:0] TX_IDLE   = 3'd0;
  localparam logic [2:0] TX_START  = 3'd1;
  localparam logic [2:0] TX_DATA   = 3'd2;
  localparam logic [2:0] TX_PARITY = 3'd3;
  localparam logic [2:0] TX_STOP   = 3'd4;
  localparam logic [2:0] RX_IDLE   = 3'd0;
  localparam logic [2:0] RX_START  = 3'd1;
  localparam logic [2:0] RX_DATA   = 3'd2;
  localparam logic [2:0] RX_PARITY = 3'd3;
  localparam logic [2:0] RX_STOP   = 3'd4;
endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: first-word-fall-through synchronous FIFO; full/empty from an extra pointer bit.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0] r_wr, r_rd;
  logic w_push, w_pop;
  assign empty = r_wr == r_rd;
  assign full = (r_wr[AW-1:0] == r_rd[AW-1:0]) && (r_wr[AW] != r_rd[AW]);
  assign w_pop = pop && !empty;
  // a pop in the same cycle frees the slot, so a full FIFO still accepts the push
  assign w_push = push && (!full || w_pop);
  assign dout = r_mem[r_rd[AW-1:0]];
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop) r_rd <= r_rd + 1'b1;
    end
  end
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wr[AW-1:0]] <= din;
endmodule

// File: rtl/uart_multi.sv
// uart_multi: bus-mapped UART with TX/RX FIFOs, 16x oversampling baud divider and IRQ.
// Parity generation/checking is built only when UART_PARITY_EN is defined.
module uart_multi #(
  parameter int          DATA_BITS  = 8,
  parameter int          FIFO_DEPTH = 16,
  parameter logic [15:0] DIV_RESET  = 16'd78
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_bit,
  output logic       tx_bit,
  input  logic [2:0] wb_addr,
  input  logic [7:0] wb_data_in,
  output logic [7:0] wb_data_out,
  input  logic       wb_we,
  input  logic       wb_stb,
  output logic       wb_ack,
  output logic       irq
);
  import uart_pkg::*;
`ifdef UART_PARITY_EN
  localparam logic PAR = 1'b1;
`else
  localparam logic PAR = 1'b0;
`endif
  localparam logic [2:0] LAST = 3'(DATA_BITS - 1);
  logic r_ack;
  logic [7:0] r_dout, w_rdata, w_status;
  logic [15:0] r_div, r_cnt;
  logic [4:0] r_ctrl;
  logic r_perr, r_ferr, r_ovr;
  logic w_acc, w_wr, w_rd, w_tick, w_div_wr, w_st_rd;
  logic w_tx_push, w_tx_pop, w_tx_full, w_tx_empty;
  logic w_rx_push, w_rx_pop, w_rx_full, w_rx_empty;
  logic [DATA_BITS-1:0] w_tx_dout, w_rx_dout;
  logic [2:0] r_tx_st, r_tx_bi, r_rx_st, r_rx_bi;
  logic [3:0] r_tx_tk, r_rx_tk;
  logic [DATA_BITS-1:0] r_tx_sh, r_rx_sh;
  logic r_tx_par, r_tx_pen, r_tx_two, r_tx_stop2;
  logic r_s1, r_s2, r_s3, r_rx_pen, r_rx_odd, r_rx_pbad;
  assign w_acc = wb_stb && !r_ack;
  assign w_wr = w_acc && wb_we;
  assign w_rd = w_acc && !wb_we;
  assign w_tx_push = w_wr && wb_addr == ADDR_TXDATA;
  assign w_div_wr = w_wr && (wb_addr == ADDR_DIV_LO || wb_addr == ADDR_DIV_HI);
  assign w_rx_pop = w_rd && wb_addr == ADDR_RXDATA;
  assign w_st_rd = w_rd && wb_addr == ADDR_STATUS;
  assign w_tick = r_cnt == r_div;
  assign w_tx_pop = w_tick && !w_tx_empty && (r_tx_st == TX_IDLE ||
                    (r_tx_st == TX_STOP && r_tx_tk == 4'd15 && (!r_tx_two || r_tx_stop2)));
  assign w_rx_push = w_tick && r_rx_st == RX_STOP && r_rx_tk == 4'd15;
  assign w_status = {1'b0, r_perr, r_ferr, r_ovr, w_rx_full, w_rx_empty, w_tx_full, w_tx_empty};
  assign wb_ack = r_ack;
  assign wb_data_out = r_dout;
  assign irq = (!w_rx_empty && r_ctrl[CT_IE_RX]) || (w_tx_empty && r_ctrl[CT_IE_TX]);
  assign tx_bit = r_tx_st == TX_START ? 1'b0 :
                  r_tx_st == TX_DATA ? r_tx_sh[0] :
                  r_tx_st == TX_PARITY ? r_tx_par : 1'b1;
  always_comb
    w_rdata = wb_addr == ADDR_RXDATA ? (w_rx_empty ? 8'h00 : 8'(w_rx_dout)) :
              wb_addr == ADDR_DIV_LO ? r_div[7:0] :
              wb_addr == ADDR_DIV_HI ? r_div[15:8] :
              wb_addr == ADDR_STATUS ? w_status :
              wb_addr == ADDR_CTRL ? {3'b000, r_ctrl} : 8'h00;
  uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .reset(reset), .push(w_tx_push), .din(wb_data_in[DATA_BITS-1:0]),
    .pop(w_tx_pop), .dout(w_tx_dout), .full(w_tx_full), .empty(w_tx_empty)
  );
  uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .reset(reset), .push(w_rx_push), .din(r_rx_sh),
    .pop(w_rx_pop), .dout(w_rx_dout), .full(w_rx_full), .empty(w_rx_empty)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ack <= 1'b0;
      r_dout <= 8'h00;
      r_div <= DIV_RESET;
      r_ctrl <= '0;
      r_perr <= 1'b0;
      r_ferr <= 1'b0;
      r_ovr <= 1'b0;
    end else begin
      r_ack <= w_acc;
      r_dout <= w_rd ? w_rdata : 8'h00;
      if (w_wr && wb_addr == ADDR_DIV_LO) r_div[7:0] <= wb_data_in;
      if (w_wr && wb_addr == ADDR_DIV_HI) r_div[15:8] <= wb_data_in;
      if (w_wr && wb_addr == ADDR_CTRL) r_ctrl <= {wb_data_in[4:2], wb_data_in[1:0] & {2{PAR}}};
      // sticky errors clear only when the STATUS read returns them; a new error in that cycle survives
      r_ovr <= (r_ovr && !w_st_rd) || (w_rx_push && w_rx_full && !w_rx_pop);
      r_ferr <= (r_ferr && !w_st_rd) || (w_rx_push && !r_s2);
      r_perr <= (r_perr && !w_st_rd) || (w_rx_push && r_rx_pbad);
    end
  end
  always_ff @(posedge clk) begin
    if (reset || w_div_wr) r_cnt <= '0;
    else r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_tx_st <= TX_IDLE;
      r_tx_tk <= '0;
      r_tx_bi <= '0;
      r_tx_sh <= '0;
      r_tx_par <= 1'b0;
      r_tx_pen <= 1'b0;
      r_tx_two <= 1'b0;
      r_tx_stop2 <= 1'b0;
    end else if (w_tx_pop) begin
      r_tx_st <= TX_START;
      r_tx_tk <= '0;
      r_tx_sh <= w_tx_dout;
      r_tx_par <= ^w_tx_dout ^ r_ctrl[CT_PAR_ODD];
      r_tx_pen <= r_ctrl[CT_PAR_EN];
      r_tx_two <= r_ctrl[CT_TWO_STOP];
      r_tx_stop2 <= 1'b0;
    end else if (w_tick && r_tx_st != TX_IDLE) begin
      r_tx_tk <= r_tx_tk + 1'b1;
      if (r_tx_tk == 4'd15)
        case (r_tx_st)
          TX_START: begin
            r_tx_st <= TX_DATA;
            r_tx_bi <= '0;
          end
          TX_DATA: begin
            r_tx_sh <= r_tx_sh >> 1;
            r_tx_bi <= r_tx_bi + 1'b1;
            if (r_tx_bi == LAST) r_tx_st <= r_tx_pen ? TX_PARITY : TX_STOP;
          end
          TX_PARITY: r_tx_st <= TX_STOP;
          default: begin
            r_tx_stop2 <= 1'b1;
            if (!r_tx_two || r_tx_stop2) r_tx_st <= TX_IDLE;
          end
        endcase
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      {r_s1, r_s2, r_s3} <= 3'b111;
      r_rx_st <= RX_IDLE;
      r_rx_tk <= '0;
      r_rx_bi <= '0;
      r_rx_sh <= '0;
      r_rx_pen <= 1'b0;
      r_rx_odd <= 1'b0;
      r_rx_pbad <= 1'b0;
    end else begin
      {r_s3, r_s2, r_s1} <= {r_s2, r_s1, rx_bit};
      if (r_rx_st == RX_IDLE) begin
        if (r_s3 && !r_s2) begin
          r_rx_st <= RX_START;
          r_rx_tk <= '0;
          r_rx_pen <= r_ctrl[CT_PAR_EN];
          r_rx_odd <= r_ctrl[CT_PAR_ODD];
          r_rx_pbad <= 1'b0;
        end
      end else if (w_tick) begin
        r_rx_tk <= r_rx_tk + 1'b1;
        // re-align the tick count at the start midpoint so later bits sample mid-cell
        if (r_rx_st == RX_START && r_rx_tk == 4'd7) begin
          r_rx_st <= r_s2 ? RX_IDLE : RX_DATA;
          r_rx_tk <= '0;
          r_rx_bi <= '0;
        end else if (r_rx_st != RX_START && r_rx_tk == 4'd15)
          case (r_rx_st)
            RX_DATA: begin
              r_rx_sh <= {r_s2, r_rx_sh[DATA_BITS-1:1]};
              r_rx_bi <= r_rx_bi + 1'b1;
              if (r_rx_bi == LAST) r_rx_st <= r_rx_pen ? RX_PARITY : RX_STOP;
            end
            RX_PARITY: begin
              r_rx_pbad <= r_s2 ^ (^r_rx_sh) ^ r_rx_odd;
              r_rx_st <= RX_STOP;
            end
            default: r_rx_st <= RX_IDLE;
          endcase
      end
    end
  end
endmodule

// File: tb/tb_uart_multi.sv
// tb_uart_multi: directed self-checking bench for uart_multi (parity steps need UART_PARITY_EN).
module tb_uart_multi;
  import uart_pkg::*;
  logic clk, reset, rx_drv, r_loop, rx_line, tx_bit, wb_we, wb_stb, wb_ack, irq;
  logic [2:0] wb_addr;
  logic [7:0] wb_data_in, wb_data_out, rd;
  logic [3:0] acks;
  logic [10:0] fr;
  int n_tests, n_fail;
  assign rx_line = r_loop ? tx_bit : rx_drv;
  uart_multi dut (
    .clk(clk), .reset(reset), .rx_bit(rx_line), .tx_bit(tx_bit),
    .wb_addr(wb_addr), .wb_data_in(wb_data_in), .wb_data_out(wb_data_out),
    .wb_we(wb_we), .wb_stb(wb_stb), .wb_ack(wb_ack), .irq(irq)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask
  task automatic do_reset();
    reset = 1'b1;
    rx_drv = 1'b1;
    r_loop = 1'b0;
    wb_stb = 1'b0;
    wb_we = 1'b0;
    wb_addr = 3'd0;
    wb_data_in = 8'h00;
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask
  task automatic wb_write(input logic [2:0] a, input logic [7:0] d);
    wb_addr = a;
    wb_data_in = d;
    wb_we = 1'b1;
    wb_stb = 1'b1;
    @(negedge clk);
    wb_stb = 1'b0;
    wb_we = 1'b0;
    @(negedge clk);
  endtask
  task automatic wb_read(input logic [2:0] a, output logic [7:0] d);
    wb_addr = a;
    wb_we = 1'b0;
    wb_stb = 1'b1;
    @(negedge clk);
    d = wb_data_out;
    wb_stb = 1'b0;
    @(negedge clk);
  endtask
  task automatic read_check(input string tag, input logic [2:0] a, input logic [7:0] exp);
    logic [7:0] v;
    wb_read(a, v);
    check(tag, v, exp);
  endtask
  task automatic send_frame(input logic [7:0] d, input int bt, input logic pen, input logic par, input logic stop);
    rx_drv = 1'b0;
    repeat (bt) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_drv = d[i];
      repeat (bt) @(negedge clk);
    end
    if (pen) begin
      rx_drv = par;
      repeat (bt) @(negedge clk);
    end
    rx_drv = stop;
    repeat (bt) @(negedge clk);
    rx_drv = 1'b1;
    repeat (4) @(negedge clk);
  endtask
  // waits for a start bit at DIV=0 and compares every clock of each 16-clock bit cell
  task automatic check_tx(input string tag, input logic [10:0] f, input int nb);
    int n;
    int bad;
    n = 0;
    while (tx_bit !== 1'b0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_start_seen"}, 8'(n < 400), 8'd1);
    for (int b = 0; b < nb; b++) begin
      bad = 0;
      for (int c = 0; c < 16; c++) begin
        if (tx_bit !== f[b]) bad++;
        @(negedge clk);
      end
      check($sformatf("%s_bit%0d_badclks", tag, b), 8'(bad), 8'd0);
    end
  endtask
  initial begin
    n_tests = 0;
    n_fail = 0;
    do_reset();
    check("rst_tx_bit", 8'(tx_bit), 8'd1);
    check("rst_ack", 8'(wb_ack), 8'd0);
    check("rst_data_out", wb_data_out, 8'h00);
    check("rst_irq", 8'(irq), 8'd0);
    read_check("rst_status", ADDR_STATUS, 8'h05);
    read_check("rst_div_lo", ADDR_DIV_LO, 8'h4E);
    read_check("rst_div_hi", ADDR_DIV_HI, 8'h00);
    read_check("rst_ctrl", ADDR_CTRL, 8'h00);
    wb_addr = ADDR_STATUS;
    wb_we = 1'b0;
    wb_stb = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      acks[3-i] = wb_ack;
    end
    wb_stb = 1'b0;
    @(negedge clk);
    check("ack_held_stb", {4'h0, acks}, 8'h0A);
    wb_write(ADDR_CTRL, 8'h1F);
`ifdef UART_PARITY_EN
    read_check("ctrl_readback", ADDR_CTRL, 8'h1F);
`else
    read_check("ctrl_readback", ADDR_CTRL, 8'h1C);
`endif
    check("irq_tx_empty", 8'(irq), 8'd1);
    wb_write(ADDR_CTRL, 8'h08);
    check("irq_rx_empty_off", 8'(irq), 8'd0);
    wb_write(3'd7, 8'hFF);
    read_check("unmapped_6", 3'd6, 8'h00);
    read_check("unmapped_7", 3'd7, 8'h00);
    read_check("txdata_read", ADDR_TXDATA, 8'h00);
    read_check("ctrl_after_unmapped", ADDR_CTRL, 8'h08);
    // 8N1 transmit of 0x55 at DIV=0
    do_reset();
    wb_write(ADDR_DIV_LO, 8'h00);
    wb_write(ADDR_TXDATA, 8'h55);
    fr = {1'b0, 1'b1, 8'h55, 1'b0};
    check_tx("tx55", fr, 10);
    // receive 0xA3 at DIV=3 (64 clocks per bit)
    do_reset();
    wb_write(ADDR_DIV_LO, 8'h03);
    send_frame(8'hA3, 64, 1'b0, 1'b0, 1'b1);
    read_check("rx_a3_data", ADDR_RXDATA, 8'hA3);
    read_check("rx_a3_status", ADDR_STATUS, 8'h05);
    read_check("rx_empty_read", ADDR_RXDATA, 8'h00);
    read_check("rx_empty_status", ADDR_STATUS, 8'h05);
    // glitch rejection then framing error
    do_reset();
    wb_write(ADDR_DIV_LO, 8'h00);
    rx_drv = 1'b0;
    repeat (4) @(negedge clk);
    rx_drv = 1'b1;
    repeat (40) @(negedge clk);
    read_check("glitch_status", ADDR_STATUS, 8'h05);
    send_frame(8'h5A, 16, 1'b0, 1'b0, 1'b0);
    read_check("ferr_status", ADDR_STATUS, 8'h21);
    read_check("ferr_cleared", ADDR_STATUS, 8'h01);
    read_check("ferr_data", ADDR_RXDATA, 8'h5A);
    read_check("ferr_final", ADDR_STATUS, 8'h05);
    // RX overrun: 17 frames, nothing read
    do_reset();
    wb_write(ADDR_DIV_LO, 8'h00);
    for (int i = 0; i < 17; i++) send_frame(8'h30 + 8'(i), 16, 1'b0, 1'b0, 1'b1);
    read_check("ovr_status", ADDR_STATUS, 8'h19);
    read_check("ovr_cleared", ADDR_STATUS, 8'h09);
    for (int i = 0; i < 16; i++) read_check($sformatf("ovr_byte%0d", i), ADDR_RXDATA, 8'h30 + 8'(i));
    read_check("ovr_final", ADDR_STATUS, 8'h05);
`ifdef UART_PARITY_EN
    do_reset();
    wb_write(ADDR_DIV_LO, 8'h00);
    wb_write(ADDR_CTRL, 8'h03);
    wb_write(ADDR_TXDATA, 8'h01);
    fr = {1'b1, 1'b0, 8'h01, 1'b0};
    check_tx("tx_odd", fr, 11);
    send_frame(8'h01, 16, 1'b1, 1'b1, 1'b1);
    read_check("perr_status", ADDR_STATUS, 8'h41);
    read_check("perr_data", ADDR_RXDATA, 8'h01);
    read_check("perr_cleared", ADDR_STATUS, 8'h05);
`endif
    // TX FIFO full with a stalled baud, then drain through loopback
    do_reset();
    wb_write(ADDR_DIV_LO, 8'hFF);
    wb_write(ADDR_DIV_HI, 8'hFF);
    for (int i = 0; i < 16; i++) wb_write(ADDR_TXDATA, 8'(i * 7 + 3));
    read_check("txfull_status", ADDR_STATUS, 8'h06);
    wb_write(ADDR_TXDATA, 8'hEE);
    read_check("txfull_drop_status", ADDR_STATUS, 8'h06);
    r_loop = 1'b1;
    wb_write(ADDR_DIV_HI, 8'h00);
    wb_write(ADDR_DIV_LO, 8'h00);
    repeat (2700) @(negedge clk);
    for (int i = 0; i < 16; i++) read_check($sformatf("loop_byte%0d", i), ADDR_RXDATA, 8'(i * 7 + 3));
    read_check("loop_final", ADDR_STATUS, 8'h05);
    r_loop = 1'b0;
    // reset in the middle of TX and RX frames
    do_reset();
    wb_write(ADDR_DIV_LO, 8'h00);
    wb_write(ADDR_TXDATA, 8'h00);
    rx_drv = 1'b0;
    repeat (40) @(negedge clk);
    check("midframe_tx_low", 8'(tx_bit), 8'd0);
    reset = 1'b1;
    rx_drv = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midframe_reset_tx", 8'(tx_bit), 8'd1);
    repeat (300) @(negedge clk);
    read_check("midframe_div_lo", ADDR_DIV_LO, 8'h4E);
    read_check("midframe_status", ADDR_STATUS, 8'h05);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
